// File: rtl/background_loader.sv
// ---------------------------------------------------------------------------
// background_loader
//
// Purpose
//    Copies one complete background tile map from the background ROM into
//    the playfield/collision tile RAM when the game state machine asks for
//    it. One ROM read is issued per cycle. A delay line that matches the ROM
//    read latency carries each tile index forward, so the write strobe, the
//    write index and the returning ROM data all line up in the same cycle.
//    The copy runs at one tile per cycle with no bubbles.
//
// Ports
//    Clk               in   1            system clock
//    Reset_n           in   1            asynchronous active-low reset
//    load_background   in   1            single-cycle load request
//    background_select in   2            map number, sampled with the load
//    rom_addr          out  2+ADDR_W     {map_sel, tile_idx} to the ROM
//    rom_data          in   TILE_W       ROM data, ROM_LAT cycles after addr
//    wr_en             out  1            tile RAM write strobe
//    wr_addr           out  ADDR_W       tile RAM write index
//    wr_data           out  TILE_W       tile RAM write data (ROM data)
//    busy              out  1            copy in progress
//    done              out  1            single-cycle completion pulse
// ---------------------------------------------------------------------------
module background_loader #(
   parameter int H_TILES = 80,
   parameter int V_TILES = 60,
   parameter int ADDR_W  = 13,
   parameter int TILE_W  = 2,
   parameter int ROM_LAT = 2
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                load_background,
   input  logic [1:0]          background_select,
   output logic [ADDR_W+1:0]   rom_addr,
   input  logic [TILE_W-1:0]   rom_data,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [TILE_W-1:0]   wr_data,
   output logic                busy,
   output logic                done
);

   localparam int N = H_TILES * V_TILES;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } loaderState_t;

   loaderState_t state_q, state_d;

   logic [1:0]        mapSel_q, mapSel_d;
   logic [ADDR_W-1:0] idx_q, idx_d;

   // Each delay line stage holds a valid flag and the tile index that was
   // issued to the ROM. The last stage is aligned with rom_data.
   logic [ROM_LAT-1:0]             dlValid_q, dlValid_d;
   logic [ROM_LAT-1:0][ADDR_W-1:0] dlIdx_q, dlIdx_d;

   logic issuing;
   logic lastWrite;

   // A ROM read is issued in every ISSUE cycle. lastWrite flags the cycle in
   // which the final tile index reaches the end of the delay line. In that
   // cycle the last write lands and the copy can finish.
   always_comb begin
      issuing   = (state_q == ISSUE);
      lastWrite = dlValid_q[ROM_LAT-1] && (dlIdx_q[ROM_LAT-1] == LAST_IDX);
   end

   // Next-state logic for the control FSM. A load request takes priority
   // in every state. From IDLE or FINISH it starts a copy. While a copy is
   // busy it restarts from tile 0 using the newly selected map. The index
   // counter stops at the last tile and never wraps.
   always_comb begin
      state_d  = state_q;
      mapSel_d = mapSel_q;
      idx_d    = idx_q;

      if (load_background) begin
         state_d  = ISSUE;
         mapSel_d = background_select;
         idx_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            ISSUE: begin
               if (idx_q == LAST_IDX) begin
                  state_d = DRAIN;
               end else begin
                  idx_d = idx_q + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (lastWrite) begin
                  state_d = FINISH;
               end
            end
            FINISH: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Next value of the latency-matching delay line. A load request empties
   // every stage. Writes still in flight from an interrupted copy are
   // dropped and never reach the RAM. Outside of ISSUE, empty entries are
   // shifted in so the pipeline drains by itself.
   always_comb begin
      dlValid_d = '0;
      dlIdx_d   = '0;
      if (!load_background) begin
         dlValid_d[0] = issuing;
         dlIdx_d[0]   = idx_q;
         for (int i = 1; i < ROM_LAT; i++) begin
            dlValid_d[i] = dlValid_q[i-1];
            dlIdx_d[i]   = dlIdx_q[i-1];
         end
      end
   end

   // State, map select, index counter and delay line registers. An
   // asynchronous reset aborts any copy in progress. All writes stop at
   // once and no completion pulse follows.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         mapSel_q  <= '0;
         idx_q     <= '0;
         dlValid_q <= '0;
         dlIdx_q   <= '0;
      end else begin
         state_q   <= state_d;
         mapSel_q  <= mapSel_d;
         idx_q     <= idx_d;
         dlValid_q <= dlValid_d;
         dlIdx_q   <= dlIdx_d;
      end
   end

   // Output decode. The ROM address is only driven during ISSUE. The write
   // side comes from the end of the delay line, and rom_data passes straight
   // through in the matching cycle. Address and data are forced to zero
   // outside the write window so the RAM bus stays quiet when idle.
   always_comb begin
      rom_addr = '0;
      if (issuing) begin
         rom_addr = {mapSel_q, idx_q};
      end

      wr_en   = dlValid_q[ROM_LAT-1];
      wr_addr = '0;
      wr_data = '0;
      if (dlValid_q[ROM_LAT-1]) begin
         wr_addr = dlIdx_q[ROM_LAT-1];
         wr_data = rom_data;
      end

      busy = (state_q == ISSUE) || (state_q == DRAIN);
      done = (state_q == FINISH);
   end

endmodule

// File: tb/tb_background_loader.sv
// ---------------------------------------------------------------------------
// tb_background_loader
//
// Bench for background_loader using a small 4x2 tile map (N = 8) and a
// two-cycle ROM. The ROM model returns (map*3 + idx) mod 4. The reference
// model only remembers when the most recent load was accepted and which
// map it selected. From that it derives every output with the timing
// arithmetic of the copy: issue, write window, busy span and done cycle.
// ---------------------------------------------------------------------------
module tb_background_loader;

   localparam int H     = 4;
   localparam int V     = 2;
   localparam int N     = H * V;
   localparam int AW    = 13;
   localparam int TW    = 2;
   localparam int LAT   = 2;
   localparam int OBS_W = 3 + AW + TW + AW + 2;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            load_background;
   logic [1:0]      background_select;
   logic [AW+1:0]   rom_addr;
   logic [TW-1:0]   rom_data;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [TW-1:0]   wr_data;
   logic            busy;
   logic            done;

   int nCompared = 0;
   int nFail     = 0;

   background_loader #(
      .H_TILES (H),
      .V_TILES (V),
      .ADDR_W  (AW),
      .TILE_W  (TW),
      .ROM_LAT (LAT)
   ) dut (
      .Clk               (Clk),
      .Reset_n           (Reset_n),
      .load_background   (load_background),
      .background_select (background_select),
      .rom_addr          (rom_addr),
      .rom_data          (rom_data),
      .wr_en             (wr_en),
      .wr_addr           (wr_addr),
      .wr_data           (wr_data),
      .busy              (busy),
      .done              (done)
   );

   // Free-running 10-unit clock.
   always #5 Clk = ~Clk;

   // ROM model: the address passes through a LAT-deep register pipe, and
   // the data for it appears LAT cycles after the address was presented.
   logic [AW+1:0] romPipe [LAT] = '{default: '0};

   function automatic logic [TW-1:0] romValue(input logic [AW+1:0] addr);
      int m;
      int k;
      m = int'(addr[AW+1:AW]);
      k = int'(addr[AW-1:0]);
      return TW'((m * 3 + k) % 4);
   endfunction

   always @(posedge Clk) begin
      romPipe[0] <= rom_addr;
      for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
   end

   assign rom_data = romValue(romPipe[LAT-1]);

   // Reference model state: the cycle number of the most recent accepted
   // load and the map it latched. A reset forgets the load.
   int       cyc       = 0;
   int       mdlT      = 0;
   logic [1:0] mdlSel  = '0;
   logic     mdlActive = 1'b0;

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mdlActive <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (load_background) begin
            mdlActive <= 1'b1;
            mdlT      <= cyc + 1;
            mdlSel    <= background_select;
         end
      end
   end

   // Expected outputs for the cycle that ends at the next rising edge.
   // d counts cycles since the governing load. Reads go out for d=1..N.
   // Writes land for d=LAT+1..N+LAT, busy covers d=1..N+LAT, and done
   // pulses at d=N+LAT+1.
   function automatic logic [OBS_W-1:0] expVec();
      logic          b;
      logic          dn;
      logic          we;
      logic [AW-1:0] wa;
      logic [TW-1:0] wd;
      logic [AW+1:0] ra;
      int            d;
      b  = 1'b0;
      dn = 1'b0;
      we = 1'b0;
      wa = '0;
      wd = '0;
      ra = '0;
      if (mdlActive) begin
         d  = cyc + 1 - mdlT;
         b  = (d >= 1) && (d <= N + LAT);
         dn = (d == N + LAT + 1);
         if (d >= 1 && d <= N) ra = {mdlSel, AW'(d - 1)};
         if (d >= LAT + 1 && d <= N + LAT) begin
            we = 1'b1;
            wa = AW'(d - 1 - LAT);
            wd = TW'((int'(mdlSel) * 3 + (d - 1 - LAT)) % 4);
         end
      end
      return {b, dn, we, wa, wd, ra};
   endfunction

   function automatic logic [OBS_W-1:0] obsVec();
      return {busy, done, wr_en, wr_addr, wr_data, rom_addr};
   endfunction

   // Reset held, then released: all outputs stay zero and nothing is written.
   task automatic test_reset();
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      int wrCnt;
      wrCnt = 0;
      load_background   = 1'b0;
      background_select = 2'd0;
      Reset_n = 1'b1;
      #2;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      obs = obsVec();
      expd = '0;
      nCompared++;
      if (obs !== expd) begin
         nFail++;
         $display("[TB] FAIL test_reset in_reset got %h expected %h", obs, expd);
      end
      Reset_n = 1'b1;
      for (int j = 0; j < 20; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_reset j=%0d got %h expected %h", j, obs, expd);
         end
         if (wr_en) wrCnt++;
      end
      nCompared++;
      if (wrCnt !== 0) begin
         nFail++;
         $display("[TB] FAIL test_reset write_count got %0d expected 0", wrCnt);
      end
   endtask

   // A single load copies all N tiles of the chosen map.
   task automatic test_basic(input logic [1:0] sel);
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      int wrCnt;
      int doneCnt;
      int busyCnt;
      wrCnt = 0;
      doneCnt = 0;
      busyCnt = 0;
      for (int j = 0; j < 16; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_basic sel=%0d j=%0d got %h expected %h", sel, j, obs, expd);
         end
         if (wr_en) wrCnt++;
         if (done) doneCnt++;
         if (busy) busyCnt++;
         load_background   = (j == 0);
         background_select = sel;
      end
      nCompared++;
      if (wrCnt !== N || doneCnt !== 1 || busyCnt !== N + LAT) begin
         nFail++;
         $display("[TB] FAIL test_basic counts got wr=%0d done=%0d busy=%0d expected wr=%0d done=1 busy=%0d",
                  wrCnt, doneCnt, busyCnt, N, N + LAT);
      end
   endtask

   // A second load during a copy restarts it. Only the new map finishes.
   task automatic test_restart(input logic [1:0] sel1, input logic [1:0] sel2);
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      int wrCnt;
      int doneCnt;
      wrCnt = 0;
      doneCnt = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_restart j=%0d got %h expected %h", j, obs, expd);
         end
         if (wr_en) wrCnt++;
         if (done) doneCnt++;
         load_background   = (j == 0) || (j == 4);
         background_select = (j < 4) ? sel1 : sel2;
      end
      nCompared++;
      if (wrCnt !== 2 + N || doneCnt !== 1) begin
         nFail++;
         $display("[TB] FAIL test_restart counts got wr=%0d done=%0d expected wr=%0d done=1",
                  wrCnt, doneCnt, 2 + N);
      end
   endtask

   // Reset in the middle of a copy stops it at once. A later load copies normally.
   task automatic test_reset_mid();
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      logic [1:0] sel;
      int wrCnt;
      int doneCnt;
      wrCnt = 0;
      doneCnt = 0;
      sel = 2'($urandom_range(0, 3));
      for (int j = 0; j < 26; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_reset_mid j=%0d got %h expected %h", j, obs, expd);
         end
         if (wr_en && j >= 10) wrCnt++;
         if (done) doneCnt++;
         load_background   = (j == 0) || (j == 10);
         background_select = sel;
         if (j == 5) begin
            Reset_n = 1'b0;
            #1;
            obs = obsVec();
            expd = '0;
            nCompared++;
            if (obs !== expd) begin
               nFail++;
               $display("[TB] FAIL test_reset_mid async_drop got %h expected %h", obs, expd);
            end
         end
         if (j == 7) Reset_n = 1'b1;
      end
      nCompared++;
      if (wrCnt !== N || doneCnt !== 1) begin
         nFail++;
         $display("[TB] FAIL test_reset_mid counts got wr=%0d done=%0d expected wr=%0d done=1",
                  wrCnt, doneCnt, N);
      end
   endtask

   // A load in the FINISH cycle: done still pulses and a second copy follows.
   task automatic test_back_to_back();
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      logic [1:0] sel1;
      logic [1:0] sel2;
      int wrCnt;
      int doneCnt;
      wrCnt = 0;
      doneCnt = 0;
      sel1 = 2'($urandom_range(0, 3));
      sel2 = 2'($urandom_range(0, 3));
      for (int j = 0; j < 26; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_back_to_back j=%0d got %h expected %h", j, obs, expd);
         end
         if (wr_en) wrCnt++;
         if (done) doneCnt++;
         load_background   = (j == 0) || (j == N + LAT + 1);
         background_select = (j <= N + LAT) ? sel1 : sel2;
      end
      nCompared++;
      if (wrCnt !== 2 * N || doneCnt !== 2) begin
         nFail++;
         $display("[TB] FAIL test_back_to_back counts got wr=%0d done=%0d expected wr=%0d done=2",
                  wrCnt, doneCnt, 2 * N);
      end
   endtask

   // Toggling the select without a load has no effect on the copy.
   task automatic test_select_toggle();
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      logic [1:0] sel;
      int wrCnt;
      int doneCnt;
      wrCnt = 0;
      doneCnt = 0;
      sel = 2'($urandom_range(0, 3));
      for (int j = 0; j < 16; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_select_toggle j=%0d got %h expected %h", j, obs, expd);
         end
         if (wr_en) wrCnt++;
         if (done) doneCnt++;
         load_background   = (j == 0);
         background_select = (j == 0) ? sel : 2'($urandom_range(0, 3));
      end
      nCompared++;
      if (wrCnt !== N || doneCnt !== 1) begin
         nFail++;
         $display("[TB] FAIL test_select_toggle counts got wr=%0d done=%0d expected wr=%0d done=1",
                  wrCnt, doneCnt, N);
      end
   endtask

   // Random loads and selects, including restarts and loads in FINISH.
   task automatic test_random();
      logic [OBS_W-1:0] obs;
      logic [OBS_W-1:0] expd;
      for (int j = 0; j < 220; j++) begin
         @(negedge Clk);
         obs = obsVec();
         expd = expVec();
         nCompared++;
         if (obs !== expd) begin
            nFail++;
            $display("[TB] FAIL test_random j=%0d got %h expected %h", j, obs, expd);
         end
         load_background   = (j < 200) && ($urandom_range(0, 13) == 0);
         background_select = 2'($urandom_range(0, 3));
      end
   endtask

   initial begin
      Reset_n           = 1'b1;
      load_background   = 1'b0;
      background_select = 2'd0;
      test_reset();
      test_basic(2'd2);
      test_basic(2'($urandom_range(0, 3)));
      test_restart(2'd1, 2'd3);
      test_restart(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      test_reset_mid();
      test_back_to_back();
      test_select_toggle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
      $finish;
   end

endmodule
